// File: rtl/rr_sel_pkg.sv
// Shared types and the round-robin pick function for the 4-channel select arbiter.
// Pure package: no state, no latency.
package rr_sel_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scans ptr+1, ptr+2, ... ptr (mod NCH); the nearest set bit after ptr wins.
  function automatic pick_t rr_pick(input logic [NCH-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] c;
    p = '0;
    for (int k = NCH; k >= 1; k--) begin
      c = ptr + SEL_W'(k);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_sel_pick.sv
// Combinational round-robin priority encoder (req, ptr -> idx, found).
// Zero latency; no flow control.
module rr_sel_pick
  import rr_sel_pkg::*;
(
  input  logic [NCH-1:0]   req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);

  pick_t p;

  always_comb begin
    p       = rr_pick(req_i, ptr_i);
    idx_o   = p.idx;
    found_o = p.found;
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin grant arbiter driving a 4:1 mux select; grant 1 cycle after req, held up to HOLD_CYC cycles.
// Release on hold expiry, done, or dropped request re-arbitrates the same cycle. Optional RR_SEL_ARBITER_GRANT_CNT_EN adds per-channel grant counters.
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   grant,
`ifdef RR_SEL_ARBITER_GRANT_CNT_EN
  output logic [31:0]      grant_cnt,
`endif
  output logic             busy
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic [NCH-1:0]   grant_q;
  logic             busy_q;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             release_d;
  logic             arb_d;

  // While granting, ptr_q equals the owner, so the released channel is already lowest priority.
  rr_sel_pick u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    release_d = (state_q == GRANT) && ((cnt_q == '0) || done || !req[sel_q]);
    arb_d     = (state_q == IDLE) || release_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= SEL_W'(NCH - 1);
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else if (arb_d) begin
      if (pick_found) begin
        state_q <= GRANT;
        cnt_q   <= CNT_W'(HOLD_CYC - 1);
        ptr_q   <= pick_idx;
        sel_q   <= pick_idx;
        grant_q <= NCH'(1) << pick_idx;
        busy_q  <= 1'b1;
      end else begin
        state_q <= IDLE;
        grant_q <= '0;
        busy_q  <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

`ifdef RR_SEL_ARBITER_GRANT_CNT_EN
  logic [NCH-1:0][7:0] gcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q <= '0;
    end else if (arb_d && pick_found && (gcnt_q[pick_idx] != 8'hFF)) begin
      gcnt_q[pick_idx] <= gcnt_q[pick_idx] + 8'd1;
    end
  end

  assign grant_cnt = gcnt_q;
`endif

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Randomized and directed checks of rr_sel_arbiter against a cycle-level ownership model.
module tb_rr_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
`ifdef RR_SEL_ARBITER_GRANT_CNT_EN
  logic [31:0] grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the mux, how many cycles it has held, last winner, per-channel grant totals.
  int m_owner;
  int m_held;
  int m_last;
  int m_sel;
  int m_gcnt[4];

  rr_sel_arbiter #(.HOLD_CYC(HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .sel   (sel),
    .grant (grant),
`ifdef RR_SEL_ARBITER_GRANT_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_sel   = 0;
    for (int i = 0; i < 4; i++) m_gcnt[i] = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic d);
    bit rearb;
    int win;
    rearb = (m_owner < 0) || (m_held == HOLD) || d || !r[m_owner];
    if (rearb) begin
      win = -1;
      for (int j = 1; j <= 4; j++)
        if (win < 0 && r[(m_last + j) % 4]) win = (m_last + j) % 4;
      if (win >= 0) begin
        m_owner = win;
        m_last  = win;
        m_sel   = win;
        m_held  = 1;
        if (m_gcnt[win] < 255) m_gcnt[win]++;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_held++;
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_cnt;
    chk("sel", sel, m_sel);
    chk("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("busy", busy, (m_owner >= 0) ? 1 : 0);
`ifdef RR_SEL_ARBITER_GRANT_CNT_EN
    exp_cnt = {m_gcnt[3][7:0], m_gcnt[2][7:0], m_gcnt[1][7:0], m_gcnt[0][7:0]};
    chk("grant_cnt", grant_cnt, exp_cnt);
`else
    exp_cnt = 0;
`endif
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0;
    done  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    req   = 4'b0;
    done  = 1'b0;
    model_reset();
    #12;
    chk("rst_sel", sel, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full request: 0,0,0,0,1,1,1,1,... with no gaps, first grant one cycle after req.
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 1'b0);
      chk("rot_sel", sel, (i / HOLD) % 4);
      chk("rot_busy", busy, 1);
    end

    // Single-cycle pulse from idle.
    step(4'b0000, 1'b0);
    chk("idle_busy", busy, 0);
    step(4'b0100, 1'b0);
    chk("pulse_grant", grant, 4'b0100);
    chk("pulse_sel", sel, 2);
    step(4'b0000, 1'b0);
    chk("pulse_after_grant", grant, 0);
    chk("pulse_after_busy", busy, 0);

    // Early release with done on channel 0's second cycle; channel 1 then holds a full period.
    step(4'b0011, 1'b0);
    chk("done_first", sel, 0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    chk("done_next", grant, 4'b0010);
    for (int i = 0; i < HOLD - 1; i++) begin
      step(4'b0011, 1'b0);
      chk("done_hold", sel, 1);
    end
    step(4'b0011, 1'b0);
    chk("done_rotate", sel, 0);

    // Lone requester is re-granted back to back.
    for (int i = 0; i < 10; i++) begin
      step(4'b1000, 1'b0);
      chk("solo_busy", busy, 1);
      chk("solo_sel", sel, 3);
    end
    step(4'b0000, 1'b0);

    // Asynchronous reset in the middle of a channel 2 grant.
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(4'b1111, 1'b0);
      if (grant == 4'b0100) hit = 1;
    end
    chk("find_ch2", {31'b0, hit}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_busy", busy, 0);
    model_reset();
    #2 rst_n = 1'b1;
    step(4'b1111, 1'b0);
    chk("post_rst_sel", sel, 0);
    chk("post_rst_grant", grant, 4'b0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++)
      step(4'($urandom), ($urandom_range(0, 7) == 0));

`ifdef RR_SEL_ARBITER_GRANT_CNT_EN
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
    end
    chk("gcnt_sat", grant_cnt, 32'h0000_00FF);
`endif

    do_reset();
    chk("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
